pl_mem_arbiter: RTL and testbench
=================================

# pl_mem_arbiter

Single-port unified-memory arbiter for the 5-stage pipeline. It shares one instruction+data memory between the IF fetch port and the MEM-stage load/store port. It sequences fixed-latency reads with a small FSM, gives priority to the older (MEM-stage) instruction, bounds IF starvation, and drives per-port stall signals that feed the PC/IF-ID freeze logic and the MEM-stage hold.

## Interface
- LATENCY, 2: cycles from read issue to `mem_rdata` valid; legal range ≥1.
- MAX_DM_STREAK, 4: consecutive DM grants allowed while IF is waiting, before IF is forced; legal range ≥1.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  global pipeline enable. While low, the block freezes and issues nothing.
- if_req  in  1  fetch read request; held high until `if_valid`.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetch data; meaningful only when `if_valid`=1.
- if_valid  out  1  one-cycle fetch completion.
- stall_if  out  1  `if_req && !if_valid`.
- dm_req  in  1  data request; held high until `dm_valid`.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; meaningful only when `dm_valid`=1.
- dm_valid  out  1  one-cycle data completion.
- stall_dm  out  1  `dm_req && !dm_valid`.
- mem_req  out  1  one-cycle issue strobe to memory.
- mem_we  out  1  write strobe, qualified by `mem_req`.
- mem_addr  out  32  issued address.
- mem_wdata  out  32  issued write data.
- mem_rdata  in  32  read data; valid exactly LATENCY cycles after a read issue.

## Operation
- **States:**
  - IDLE: accepts a grant.
  - BUSY_IF: IF read outstanding.
  - BUSY_DM: DM read outstanding.
- **Grant in IDLE** (only when `enable`=1):
  - Only one of `dm_req`/`if_req` high: that port wins.
  - Both high: DM wins, unless `dm_streak`==MAX_DM_STREAK, in which case IF wins.
- **On a grant:**
  - `mem_req`=1 in the same cycle.
  - `mem_addr`/`mem_we`/`mem_wdata` are taken combinationally from the granted port. IF grants drive `mem_we`=0 and `mem_wdata`=0.
- **Store grant:**
  - Completes in the issue cycle: `dm_valid`=1 in that cycle.
  - State stays IDLE.
  - A pending IF is served next cycle at the earliest.
- **Read grant:**
  - Load `cnt` ← LATENCY−1.
  - Go to BUSY_IF or BUSY_DM.
- **In BUSY_x:**
  - `cnt`≠0: decrement `cnt`.
  - `cnt`==0: completion cycle. `x_valid`=1, `x_rdata`=`mem_rdata` (pass-through), next state IDLE.
  - No new grant in a completion cycle.
- **`dm_streak`:**
  - DM grant with `if_req`=1: increment, saturating at MAX_DM_STREAK.
  - IF grant, or DM grant with `if_req`=0: clear to 0.
- **Outside the completion cycle:**
  - `if_rdata`/`dm_rdata` are driven to 0.
  - Valids are 0.
- **Requester drops `req` mid-transaction** (e.g. branch flush): the transaction still runs to completion and its valid pulses. The requester ignores it. The stall output follows the dropped `req` and goes low immediately.
- **`enable`=0:**
  - State, `cnt` and `dm_streak` hold.
  - `mem_req`, `if_valid` and `dm_valid` are forced to 0.
  - Stalls follow their formulas.
  - The memory is frozen by the same `enable`.

## Timing
- **Reset** (`reset`=0 at a rising edge):
  - State ← IDLE, `cnt` ← 0, `dm_streak` ← 0.
  - While `reset`=0, all outputs are 0, including stalls.
- **Reset mid-transaction:** the outstanding read is abandoned and its valid is never produced.
- **Read latency:** grant at cycle t → `x_valid` at t+LATENCY. The next grant is possible at t+LATENCY+1. Peak read throughput is 1 per LATENCY+1 cycles.
- **Store latency:** 0 extra cycles. Back-to-back stores may issue every cycle.
- **Sequential logic:** only state, `cnt` and `dm_streak` are registered. All other outputs are combinational from state, inputs and `mem_rdata`.
- **Width:** `cnt` is $clog2(LATENCY+1) bits; `dm_streak` is $clog2(MAX_DM_STREAK+1) bits.

## Structure
- Shared package `pl_mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, BUSY_IF, BUSY_DM}.
  - Default LATENCY and MAX_DM_STREAK constants, reused by the memory model and the bench.
- Sub-module `pl_latency_counter`: load/decrement/zero-flag, with enable and sync active-low reset.
- Everything else (grant logic, streak counter, output muxing) lives in `pl_mem_arbiter`.

## Test plan
- **Lone IF read:** LATENCY=2, IF read @0x40 granted at cycle 5 → `mem_req`=1 in cycle 5 only; `if_valid`=1 in cycle 7 with `if_rdata`=`mem_rdata`; `stall_if` high in cycles 5–6, low in 7.
- **Conflict:** `if_req` and `dm_req` (load @0x100) rise together → DM granted first (`dm_valid` at t+2), IF granted at t+3, `if_valid` at t+5.
- **Starvation bound:** MAX_DM_STREAK=4, `dm_req` held continuously with loads, `if_req` high → exactly 4 DM grants, then 1 IF grant, then DM resumes.
- **Store then fetch:** store 0xDEADBEEF @0x200 with IF pending → `dm_valid`, `mem_we`=1 in the same cycle; IF granted the next cycle; later load @0x200 returns 0xDEADBEEF.
- **Flush and enable:** `if_req` dropped during BUSY_IF → `stall_if`=0 immediately and `if_valid` still pulses at t+LATENCY. `enable`=0 for 3 cycles mid-read → completion slips exactly 3 cycles.
- **Reset mid-transaction:** `reset`=0 during BUSY_DM → next cycle state is IDLE, no `dm_valid`, and all outputs are 0 while `reset`=0.

Source files
------------

// File: rtl/pl_mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Contents:
//   arb_state_t        : arbiter FSM state encoding
//   DEF_LATENCY        : default memory read latency (cycles from issue to data)
//   DEF_MAX_DM_STREAK  : default number of back-to-back DM grants allowed while IF waits
package pl_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_LATENCY       = 2;
  localparam int unsigned DEF_MAX_DM_STREAK = 4;

endpackage

// File: rtl/pl_latency_counter.sv
// Down-counter that tracks the cycles remaining on an outstanding memory read.
// Ports:
//   i_clk      : rising-edge clock
//   i_reset    : synchronous active-low reset (clears the count)
//   i_en       : count enable; when low the count holds
//   i_load     : load i_load_val (takes priority over decrement)
//   i_load_val : value loaded on i_load
//   i_dec      : decrement request; the count never wraps below zero
//   o_zero     : count is zero
module pl_latency_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
        r_cnt <= r_cnt - WIDTH'(1);
      end
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pl_mem_arbiter.sv
// Single-port unified-memory arbiter between the IF fetch port and the
// MEM-stage load/store port. DM has priority, but IF is forced through after
// MAX_DM_STREAK consecutive DM grants taken while IF was waiting.
// Stores complete in their issue cycle; reads complete LATENCY cycles after issue.
// Ports:
//   clk, reset (sync, active-low), enable (global freeze when low)
//   if_req/if_addr -> if_rdata/if_valid/stall_if           : fetch port
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_valid/stall_dm : data port
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata           : memory side
module pl_mem_arbiter
  import pl_mem_arb_pkg::*;
#(
  parameter int unsigned LATENCY       = DEF_LATENCY,
  parameter int unsigned MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        stall_if,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        stall_dm,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam int unsigned STK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DM_STREAK);

  arb_state_t       r_state;
  logic [STK_W-1:0] r_streak;

  logic w_active;
  logic w_idle;
  logic w_grant_dm;
  logic w_grant_if;
  logic w_read_grant;
  logic w_cnt_zero;
  logic w_done;
  logic w_if_done;
  logic w_dm_done;
  logic w_store;

  // Nothing is granted or completed while in reset or frozen.
  assign w_active = reset & enable;
  assign w_idle   = (r_state == IDLE);

  // DM wins a tie unless IF has already been passed over MAX_DM_STREAK times.
  assign w_grant_dm   = w_active & w_idle & dm_req & (~if_req | (r_streak != STK_MAX));
  assign w_grant_if   = w_active & w_idle & if_req & ~w_grant_dm;
  assign w_store      = w_grant_dm & dm_we;
  assign w_read_grant = w_grant_if | (w_grant_dm & ~dm_we);

  assign w_done    = w_active & ~w_idle & w_cnt_zero;
  assign w_if_done = w_done & (r_state == BUSY_IF);
  assign w_dm_done = w_done & (r_state == BUSY_DM);

  pl_latency_counter #(
    .WIDTH(CNT_W)
  ) u_lat_cnt (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_en      (enable),
    .i_load    (w_read_grant),
    .i_load_val(CNT_LOAD),
    .i_dec     (~w_idle),
    .o_zero    (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_streak <= '0;
    end else if (enable) begin
      case (r_state)
        IDLE: begin
          if (w_grant_dm) begin
            if (!dm_we) r_state <= BUSY_DM;
            if (if_req) begin
              if (r_streak != STK_MAX) r_streak <= r_streak + STK_W'(1);
            end else begin
              r_streak <= '0;
            end
          end else if (w_grant_if) begin
            r_state  <= BUSY_IF;
            r_streak <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (w_cnt_zero) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req   = w_grant_dm | w_grant_if;
    mem_we    = w_store;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_grant_dm) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (w_grant_if) begin
      mem_addr  = if_addr;
    end
  end

  assign if_valid = w_if_done;
  assign if_rdata = w_if_done ? mem_rdata : '0;
  assign dm_valid = w_dm_done | w_store;
  assign dm_rdata = w_dm_done ? mem_rdata : '0;

  // Stalls track the live request, so a dropped request releases immediately.
  assign stall_if = reset & if_req & ~w_if_done;
  assign stall_dm = reset & dm_req & ~(w_dm_done | w_store);

endmodule

// File: tb/tb_pl_mem_arbiter.sv
// Directed bench for pl_mem_arbiter with a fixed-latency memory model.
// Unwritten words read back as 32'h1000_0000 | byte address.
module tb_pl_mem_arbiter;
  import pl_mem_arb_pkg::*;

  localparam int unsigned LAT = DEF_LATENCY;
  localparam int unsigned MDS = DEF_MAX_DM_STREAK;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, stall_if, dm_valid, stall_dm, mem_req, mem_we;
  logic [5:0]  ctl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pl_mem_arbiter #(.LATENCY(LAT), .MAX_DM_STREAK(MDS)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .stall_if(stall_if),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_dm(stall_dm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign ctl = {mem_req, mem_we, if_valid, dm_valid, stall_if, stall_dm};

  // Memory model: data presented exactly LAT enabled cycles after a read issue.
  logic [31:0] mem [0:255];
  logic [31:0] m_addr;
  int unsigned m_cnt;
  logic        m_armed;

  always @(posedge clk) begin
    if (!reset) begin
      m_armed <= 1'b0;
      m_cnt   <= 0;
      m_addr  <= '0;
      for (int unsigned i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | (i << 2);
    end else if (enable) begin
      if (mem_req && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_req && !mem_we) begin
        m_addr  <= mem_addr;
        m_cnt   <= LAT - 1;
        m_armed <= 1'b1;
      end else if (m_armed) begin
        if (m_cnt == 0) m_armed <= 1'b0;
        else m_cnt <= m_cnt - 1;
      end
    end
  end

  assign mem_rdata = (m_armed && m_cnt == 0) ? mem[m_addr[9:2]] : 32'hBAD0_BAD0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    cyc(); if_req = 1; dm_req = 1; dm_we = 1; if_addr = 32'h40; dm_addr = 32'h80; dm_wdata = 32'h55;
    settle();
    n_checks++;
    if ({ctl, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h ir=%h dr=%h, want all 0",
               ctl, mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    cyc(); reset = 1; if_req = 0; dm_req = 0; dm_we = 0; settle();
    n_checks++;
    if (ctl !== 6'b000000) begin
      n_fail++; $display("FAIL reset_idle: ctl=%b want 000000", ctl);
    end
  endtask

  task automatic test_lone_if();
    cyc(); if_req = 1; if_addr = 32'h40; settle();
    n_checks++;
    if ({ctl, mem_addr, mem_wdata} !== {6'b100010, 32'h40, 32'h0}) begin
      n_fail++; $display("FAIL lone_if_issue: ctl=%b addr=%h wdata=%h want 100010 00000040 0", ctl, mem_addr, mem_wdata);
    end
    cyc(); settle();
    n_checks++;
    if ({ctl, if_rdata} !== {6'b000010, 32'h0}) begin
      n_fail++; $display("FAIL lone_if_wait: ctl=%b rdata=%h want 000010 0", ctl, if_rdata);
    end
    cyc(); settle();
    n_checks++;
    if ({ctl, if_rdata} !== {6'b001000, 32'h1000_0040}) begin
      n_fail++; $display("FAIL lone_if_done: ctl=%b rdata=%h want 001000 10000040", ctl, if_rdata);
    end
    cyc(); if_req = 0; settle();
    n_checks++;
    if (ctl !== 6'b000000) begin
      n_fail++; $display("FAIL lone_if_after: ctl=%b want 000000", ctl);
    end
  endtask

  task automatic test_conflict();
    cyc(); if_req = 1; if_addr = 32'h80; dm_req = 1; dm_we = 0; dm_addr = 32'h100; settle();
    n_checks++;
    if ({ctl, mem_addr} !== {6'b100011, 32'h100}) begin
      n_fail++; $display("FAIL conflict_dm_first: ctl=%b addr=%h want 100011 00000100", ctl, mem_addr);
    end
    cyc(); settle();
    n_checks++;
    if (ctl !== 6'b000011) begin
      n_fail++; $display("FAIL conflict_wait: ctl=%b want 000011", ctl);
    end
    cyc(); settle();
    n_checks++;
    if ({ctl, dm_rdata} !== {6'b000110, 32'h1000_0100}) begin
      n_fail++; $display("FAIL conflict_dm_done: ctl=%b rdata=%h want 000110 10000100", ctl, dm_rdata);
    end
    cyc(); dm_req = 0; settle();
    n_checks++;
    if ({ctl, mem_addr} !== {6'b100010, 32'h80}) begin
      n_fail++; $display("FAIL conflict_if_grant: ctl=%b addr=%h want 100010 00000080", ctl, mem_addr);
    end
    cyc(); cyc(); settle();
    n_checks++;
    if ({ctl, if_rdata} !== {6'b001000, 32'h1000_0080}) begin
      n_fail++; $display("FAIL conflict_if_done: ctl=%b rdata=%h want 001000 10000080", ctl, if_rdata);
    end
    cyc(); if_req = 0;
  endtask

  task automatic test_starvation();
    logic        is_if;
    logic [31:0] exp_addr;
    cyc(); if_req = 1; if_addr = 32'h44; dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    for (int w = 0; w < 6; w++) begin
      is_if    = (w == 4);
      exp_addr = is_if ? 32'h44 : 32'h300;
      if (w != 0) cyc();
      settle();
      n_checks++;
      if ({ctl, mem_addr} !== {6'b100011, exp_addr}) begin
        n_fail++; $display("FAIL starve_grant%0d: ctl=%b addr=%h want 100011 %h", w, ctl, mem_addr, exp_addr);
      end
      cyc(); settle();
      n_checks++;
      if (ctl !== 6'b000011) begin
        n_fail++; $display("FAIL starve_wait%0d: ctl=%b want 000011", w, ctl);
      end
      cyc(); settle();
      n_checks++;
      if (ctl !== (is_if ? 6'b001001 : 6'b000110)) begin
        n_fail++; $display("FAIL starve_done%0d: ctl=%b want %b", w, ctl, is_if ? 6'b001001 : 6'b000110);
      end
    end
    cyc(); if_req = 0; dm_req = 0; settle();
    n_checks++;
    if (ctl !== 6'b000000) begin
      n_fail++; $display("FAIL starve_after: ctl=%b want 000000", ctl);
    end
  endtask

  task automatic test_store_fetch();
    cyc(); dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; if_req = 1; if_addr = 32'h48;
    settle();
    n_checks++;
    if ({ctl, mem_addr, mem_wdata, dm_rdata} !== {6'b110110, 32'h200, 32'hDEAD_BEEF, 32'h0}) begin
      n_fail++; $display("FAIL store_issue: ctl=%b addr=%h wdata=%h dr=%h want 110110 00000200 deadbeef 0",
                         ctl, mem_addr, mem_wdata, dm_rdata);
    end
    cyc(); dm_req = 0; dm_we = 0; settle();
    n_checks++;
    if ({ctl, mem_addr, mem_wdata} !== {6'b100010, 32'h48, 32'h0}) begin
      n_fail++; $display("FAIL store_then_if: ctl=%b addr=%h wdata=%h want 100010 00000048 0", ctl, mem_addr, mem_wdata);
    end
    cyc(); cyc(); settle();
    n_checks++;
    if ({ctl, if_rdata} !== {6'b001000, 32'h1000_0048}) begin
      n_fail++; $display("FAIL store_if_done: ctl=%b rdata=%h want 001000 10000048", ctl, if_rdata);
    end
    cyc(); if_req = 0; dm_req = 1; dm_we = 1; dm_addr = 32'h204; dm_wdata = 32'h1234_5678; settle();
    n_checks++;
    if ({ctl, mem_addr, mem_wdata} !== {6'b110100, 32'h204, 32'h1234_5678}) begin
      n_fail++; $display("FAIL b2b_store0: ctl=%b addr=%h wdata=%h want 110100 00000204 12345678", ctl, mem_addr, mem_wdata);
    end
    cyc(); dm_addr = 32'h208; dm_wdata = 32'h0BAD_F00D; settle();
    n_checks++;
    if ({ctl, mem_addr, mem_wdata} !== {6'b110100, 32'h208, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL b2b_store1: ctl=%b addr=%h wdata=%h want 110100 00000208 0badf00d", ctl, mem_addr, mem_wdata);
    end
    cyc(); dm_we = 0; dm_addr = 32'h200; settle();
    n_checks++;
    if ({ctl, mem_addr} !== {6'b100001, 32'h200}) begin
      n_fail++; $display("FAIL load_back_issue: ctl=%b addr=%h want 100001 00000200", ctl, mem_addr);
    end
    cyc(); cyc(); settle();
    n_checks++;
    if ({ctl, dm_rdata} !== {6'b000100, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL load_back_200: ctl=%b rdata=%h want 000100 deadbeef", ctl, dm_rdata);
    end
    cyc(); dm_addr = 32'h208; cyc(); cyc(); settle();
    n_checks++;
    if ({ctl, dm_rdata} !== {6'b000100, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL load_back_208: ctl=%b rdata=%h want 000100 0badf00d", ctl, dm_rdata);
    end
    cyc(); dm_req = 0;
  endtask

  task automatic test_flush();
    cyc(); if_req = 1; if_addr = 32'h4C; settle();
    n_checks++;
    if ({ctl, mem_addr} !== {6'b100010, 32'h4C}) begin
      n_fail++; $display("FAIL flush_issue: ctl=%b addr=%h want 100010 0000004c", ctl, mem_addr);
    end
    cyc(); if_req = 0; settle();
    n_checks++;
    if (ctl !== 6'b000000) begin
      n_fail++; $display("FAIL flush_stall_drop: ctl=%b want 000000", ctl);
    end
    cyc(); settle();
    n_checks++;
    if ({ctl, if_rdata} !== {6'b001000, 32'h1000_004C}) begin
      n_fail++; $display("FAIL flush_still_valid: ctl=%b rdata=%h want 001000 1000004c", ctl, if_rdata);
    end
  endtask

  task automatic test_enable();
    cyc(); enable = 0; if_req = 1; if_addr = 32'h50; settle();
    n_checks++;
    if (ctl !== 6'b000010) begin
      n_fail++; $display("FAIL enable_idle_frozen: ctl=%b want 000010", ctl);
    end
    cyc(); enable = 1; settle();
    n_checks++;
    if ({ctl, mem_addr} !== {6'b100010, 32'h50}) begin
      n_fail++; $display("FAIL enable_issue: ctl=%b addr=%h want 100010 00000050", ctl, mem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(); enable = 0; settle();
      n_checks++;
      if (ctl !== 6'b000010) begin
        n_fail++; $display("FAIL enable_hold%0d: ctl=%b want 000010", k, ctl);
      end
    end
    cyc(); enable = 1; settle();
    n_checks++;
    if (ctl !== 6'b000010) begin
      n_fail++; $display("FAIL enable_resume: ctl=%b want 000010", ctl);
    end
    cyc(); settle();
    n_checks++;
    if ({ctl, if_rdata} !== {6'b001000, 32'h1000_0050}) begin
      n_fail++; $display("FAIL enable_slip_done: ctl=%b rdata=%h want 001000 10000050", ctl, if_rdata);
    end
    cyc(); if_req = 0;
  endtask

  task automatic test_reset_mid();
    cyc(); dm_req = 1; dm_we = 0; dm_addr = 32'h104; settle();
    n_checks++;
    if ({ctl, mem_addr} !== {6'b100001, 32'h104}) begin
      n_fail++; $display("FAIL rmid_issue: ctl=%b addr=%h want 100001 00000104", ctl, mem_addr);
    end
    cyc(); reset = 0; settle();
    n_checks++;
    if ({ctl, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
      n_fail++; $display("FAIL rmid_outputs: ctl=%b addr=%h dr=%h want all 0", ctl, mem_addr, dm_rdata);
    end
    cyc(); reset = 1; dm_req = 0; settle();
    n_checks++;
    if (ctl !== 6'b000000) begin
      n_fail++; $display("FAIL rmid_no_valid: ctl=%b want 000000", ctl);
    end
    cyc(); dm_req = 1; dm_addr = 32'h108; settle();
    n_checks++;
    if ({ctl, mem_addr} !== {6'b100001, 32'h108}) begin
      n_fail++; $display("FAIL rmid_regrant: ctl=%b addr=%h want 100001 00000108", ctl, mem_addr);
    end
    cyc(); cyc(); settle();
    n_checks++;
    if ({ctl, dm_rdata} !== {6'b000100, 32'h1000_0108}) begin
      n_fail++; $display("FAIL rmid_regrant_done: ctl=%b rdata=%h want 000100 10000108", ctl, dm_rdata);
    end
    cyc(); dm_req = 0;
  endtask

  initial begin
    reset = 0; enable = 1;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_lone_if();
    test_conflict();
    test_starvation();
    test_store_fetch();
    test_flush();
    test_enable();
    test_reset_mid();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion before 100000");
    $fatal(1);
  end

endmodule
